// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of spike_in over a fixed window of clk cycles
// and hands the count over a valid/ready port. Define SPIKE_SYNC_EN to add a 2-flop input synchronizer.
module spike_rate_decoder #(
  parameter int unsigned WIDTH  = 8,
  parameter logic [15:0] WINDOW = 16'd1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike_in,
  output logic [WIDTH-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic             spike_s, spike_prev;
  logic [15:0]      win_cnt;
  logic [WIDTH-1:0] spike_cnt;
  logic             edge_det, win_last, load, drop, accept;
  logic [WIDTH-1:0] result;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {{WIDTH{1'b0}}, b};
    return sum[WIDTH] ? CNT_MAX : sum[WIDTH-1:0];
  endfunction

`ifdef SPIKE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], spike_in};
  end

  assign spike_s = sync_q[1];
`else
  assign spike_s = spike_in;
`endif

  // History samples every cycle, so a level already high when COUNT starts is not an edge.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_prev <= 1'b0;
    else        spike_prev <= spike_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = en ? COUNT : IDLE;
  end

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    edge_det = 1'b0;
    win_last = 1'b0;
    if (state == COUNT) begin
      edge_det = spike_s & ~spike_prev;
      win_last = (win_cnt == WINDOW - 16'd1);
    end
    result = sat_add(spike_cnt, edge_det);
    accept = rate_valid & rate_ready;
    load   = win_last & (~rate_valid | rate_ready);
    drop   = win_last & rate_valid & ~rate_ready;
  end

  // Leaving COUNT for any reason throws away the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
    end else if (state != COUNT || win_last) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
    end else begin
      win_cnt   <= win_cnt + 16'd1;
      spike_cnt <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rate       <= result;
        rate_valid <= 1'b1;
      end else if (accept) begin
        rate_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder (WINDOW=100 and a WINDOW=600 saturation copy).
module tb_spike_rate_decoder;

`ifdef SPIKE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, spike = 1'b0, ready = 1'b0;
  logic       en2 = 1'b0, spike2 = 1'b0, ready2 = 1'b0;
  logic [7:0] rate, rate2;
  logic       valid, valid2, ovr, ovr2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WIDTH(8), .WINDOW(16'd100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike),
    .rate(rate), .rate_valid(valid), .rate_ready(ready), .overrun(ovr)
  );

  spike_rate_decoder #(.WIDTH(8), .WINDOW(16'd600)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .spike_in(spike2),
    .rate(rate2), .rate_valid(valid2), .rate_ready(ready2), .overrun(ovr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_rate", rate, 0);
    check("rst_valid", valid, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick();

    // 25 one-cycle pulses spaced 4 cycles
    en = 1'b1; ready = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      spike = (k % 4 == 0);
      tick();
      if (k == 98) check("w1_valid_early", valid, 0);
    end
    check("w1_valid", valid, 1);
    check("w1_rate", rate, 25);
    tick();
    check("w1_valid_one_cycle", valid, 0);
    check("w1_rate_hold", rate, 25);

    // Level held high 50 cycles counts once
    for (int k = 1; k < 100; k++) begin
      spike = (k >= 10 && k < 60);
      tick();
    end
    check("w2_valid", valid, 1);
    check("w2_rate", rate, 1);

    // Backpressure across two completions: 10 then 20 spikes
    for (int k = 0; k < 100; k++) begin
      ready = (k == 0);
      spike = (k % 2 == 1 && k < 21);
      tick();
    end
    check("w3_valid", valid, 1);
    check("w3_rate", rate, 10);
    check("w3_ovr", ovr, 0);
    for (int k = 0; k < 100; k++) begin
      spike = (k % 2 == 1 && k < 41);
      tick();
    end
    check("w4_rate_kept", rate, 10);
    check("w4_valid", valid, 1);
    check("w4_ovr", ovr, 1);
    ready = 1'b1;
    tick();
    check("w4_valid_cleared", valid, 0);
    check("w4_ovr_sticky", ovr, 1);
    check("w4_rate_after", rate, 10);

    // Completion coincident with a transfer loads the new result
    ready = 1'b0;
    for (int k = 1; k < 100; k++) begin
      spike = (k == 5 || k == 10 || k == 15);
      tick();
    end
    check("w5_rate", rate, 3);
    for (int k = 0; k < 100; k++) begin
      ready = (k == 99);
      spike = (k == 2 || k == 4 || k == 6 || k == 8);
      tick();
      if (k == 50) check("w6_rate_stable", rate, 3);
    end
    check("w6_valid", valid, 1);
    check("w6_rate", rate, 4);

    // Reset mid-window after 7 spikes
    ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      spike = (k % 2 == 0 && k >= 2 && k <= 14);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_rate", rate, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ovr", ovr, 0);
    spike = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      spike = (k == 10 || k == 20 || k == 30 || k == 40 || k == 50);
      tick();
    end
    check("post_rst_valid", valid, 1);
    check("post_rst_rate", rate, 5);
    check("post_rst_ovr", ovr, 0);

    // Single pulse on the last window cycle
    for (int k = 0; k < 100; k++) begin
      spike = (k == 99);
      tick();
    end
    check("last_cycle_valid", valid, 1);
    check("last_cycle_rate", rate, SYNC ? 0 : 1);
    for (int k = 0; k < 100; k++) begin
      spike = 1'b0;
      tick();
    end
    check("next_window_rate", rate, SYNC ? 1 : 0);

    // en dropped mid-window discards the partial count
    for (int k = 0; k < 50; k++) begin
      spike = (k == 5 || k == 15 || k == 25);
      tick();
    end
    en = 1'b0; spike = 1'b0;
    for (int k = 0; k < 150; k++) tick();
    check("en_drop_valid", valid, 0);
    check("en_drop_rate", rate, SYNC ? 1 : 0);
    en = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      spike = (k == 30 || k == 60);
      tick();
    end
    check("after_en_drop_rate", rate, 2);
    check("after_en_drop_valid", valid, 1);

    // Saturation: 300 edges in a 600-cycle window
    en2 = 1'b1; ready2 = 1'b1;
    tick();
    for (int k = 0; k < 600; k++) begin
      spike2 = (k % 2 == 1);
      tick();
    end
    check("sat_valid", valid2, 1);
    check("sat_rate", rate2, 255);
    check("sat_ovr", ovr2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
